// File: rtl/bram_2_hp_controller.sv
// Egress buffer: collects engine result words into a local BRAM, then issues one
// HP write-burst request and streams the words out with the last beat flagged.
module bram_2_hp_controller #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              flush,
   output logic              req_valid,
   output logic [ADDR_W:0]   req_len,
   input  logic              req_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_FILL, S_REQ, S_SEND} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
   logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] eff_len;
   logic             done_q, done_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              rd_vld_q;
   logic              rd_last_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              out_vld_q;
   logic              out_last_q;
   logic [DATA_W-1:0] out_data_q;

   logic wr_en, rd_en, out_free, rd_move, out_fire;

   // Out-of-range lengths fall back to a full buffer.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
      if (l == '0 || l > CNT_DEPTH) return CNT_DEPTH;
      return l;
   endfunction

   always_comb begin
      state_d   = state_q;
      w_cnt_d   = w_cnt_q;
      r_cnt_d   = r_cnt_q;
      len_d     = len_q;
      done_d    = 1'b0;
      in_ready  = 1'b0;
      req_valid = 1'b0;
      req_len   = '0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      eff_len   = (w_cnt_q == '0) ? clamp_len(cfg_len) : len_q;
      out_free  = !out_vld_q || out_ready;
      rd_move   = rd_vld_q && out_free;
      out_fire  = out_vld_q && out_ready;
      case (state_q)
         S_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en   = 1'b1;
               w_cnt_d = w_cnt_q + CNT_ONE;
               len_d   = eff_len;
               if (w_cnt_d == eff_len || flush) state_d = S_REQ;
            end else if (flush && w_cnt_q != '0) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            req_valid = 1'b1;
            req_len   = w_cnt_q;
            if (req_ready) state_d = S_SEND;
         end
         S_SEND: begin
            // Read only when the BRAM output register is free or draining this cycle.
            rd_en = (r_cnt_q < w_cnt_q) && (!rd_vld_q || rd_move);
            if (rd_en) r_cnt_d = r_cnt_q + CNT_ONE;
            if (out_fire && out_last_q) begin
               state_d = S_FILL;
               w_cnt_d = '0;
               r_cnt_d = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FILL;
         w_cnt_q <= '0;
         r_cnt_q <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_cnt_q <= w_cnt_d;
         r_cnt_q <= r_cnt_d;
         len_q   <= len_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[w_cnt_q[ADDR_W-1:0]] <= in_data;
      if (rd_en) begin
         rd_data_q <= mem[r_cnt_q[ADDR_W-1:0]];
         rd_last_q <= (r_cnt_q + CNT_ONE == w_cnt_q);
      end
   end

   // Output stage doubles as skid: it only advances when empty or consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         if (rd_en)        rd_vld_q <= 1'b1;
         else if (rd_move) rd_vld_q <= 1'b0;
         if (rd_move) begin
            out_vld_q  <= 1'b1;
            out_last_q <= rd_last_q;
            out_data_q <= rd_data_q;
         end else if (out_fire) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_vld_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign busy      = (state_q != S_FILL) || (w_cnt_q != '0);

endmodule

// File: tb/tb_bram_2_hp_controller.sv
// Randomized bench for bram_2_hp_controller against a burst-level queue model.
module tb_bram_2_hp_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  cfg_len;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        flush;
   logic        req_valid;
   logic [4:0]  req_len;
   logic        req_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_last;
   logic        out_ready;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   bram_2_hp_controller #(.DATA_W(64), .DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .flush(flush),
      .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, act, exp);
   endtask

   // Burst-level model: phase 0 collecting, 1 requesting, 2 sending.
   int          phase;
   logic [63:0] words[$];
   int          cur_len;
   int          beat_idx;
   int          lat;
   int          stuck;
   bit          done_exp;
   bit          prev_vld, prev_rdy, prev_last;
   logic [63:0] prev_data;

   task automatic model_reset();
      phase = 0; words.delete(); cur_len = 16; beat_idx = 0; lat = 0; stuck = 0;
      done_exp = 0; prev_vld = 0; prev_rdy = 0; prev_last = 0; prev_data = '0;
   endtask

   task automatic cycle(input bit rnd, input logic iv, input logic [63:0] d, input logic fl,
                        input logic [4:0] cl, input logic rr, input logic orr);
      @(negedge clk);
      if (phase == 2) lat++;
      chk("in_ready", in_ready, phase == 0);
      chk("busy", busy, (phase != 0) || (words.size() != 0));
      chk("done", done, done_exp);
      chk("req_valid", req_valid, phase == 1);
      if (req_valid) chk("req_len", req_len, words.size());
      if (phase == 2 && beat_idx == 0 && lat <= 3) chk("first_beat_latency", out_valid, lat == 3);
      if (prev_vld && !prev_rdy) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, prev_data);
         chk("stall_last", out_last, prev_last);
      end
      if (out_valid) begin
         if (phase == 2 && beat_idx < words.size()) begin
            chk("beat_data", out_data, words[beat_idx]);
            chk("beat_last", out_last, beat_idx == words.size() - 1);
         end else begin
            chk("spurious_beat", out_valid, 0);
         end
      end
      if (rnd) begin
         iv = ($urandom_range(0, 3) != 0);
         d  = {$urandom, $urandom};
         fl = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 5))
            0:       cl = 5'd0;
            1:       cl = 5'd20;
            default: cl = 5'($urandom_range(1, 16));
         endcase
         rr  = $urandom_range(0, 1);
         orr = ($urandom_range(0, 3) != 0);
      end
      in_valid = iv; in_data = d; flush = fl; cfg_len = cl; req_ready = rr; out_ready = orr;
      prev_vld = out_valid; prev_rdy = orr; prev_data = out_data; prev_last = out_last;
      done_exp = 0;
      case (phase)
         0: begin
            if (iv) begin
               if (words.size() == 0) cur_len = (cl == 0 || cl > 16) ? 16 : int'(cl);
               words.push_back(d);
               if (words.size() == cur_len || fl) phase = 1;
            end else if (fl && words.size() > 0) begin
               phase = 1;
            end
         end
         1: if (rr) begin phase = 2; lat = 0; beat_idx = 0; end
         2: if (out_valid && orr) begin
            beat_idx++;
            if (beat_idx == words.size()) begin
               phase = 0; words.delete(); done_exp = 1;
            end
         end
         default: ;
      endcase
      if (phase == 2 && !(out_valid && orr)) stuck++;
      else stuck = 0;
      if (stuck > 64) begin
         chk("send_timeout", stuck, 0);
         stuck = 0;
      end
   endtask

   task automatic fill(input int n, input logic [63:0] base, input logic [4:0] cl_first,
                       input logic [4:0] cl_rest, input bit fl_last);
      for (int i = 0; i < n; i++)
         cycle(0, 1, base + 64'(i), fl_last && (i == n - 1), (i == 0) ? cl_first : cl_rest, 0, 0);
   endtask

   task automatic drain(input bit toggled);
      for (int i = 0; i < 400 && phase != 0; i++)
         cycle(0, 0, '0, 0, 5'd16, 1, toggled ? (i % 3 == 0) : 1'b1);
      if (phase != 0) chk("drain_timeout", phase, 0);
      cycle(0, 0, '0, 0, 5'd16, 0, 1);
   endtask

   task automatic check_reset();
      chk("rst_req_valid", req_valid, 0);
      chk("rst_req_len", req_len, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
   endtask

   initial begin
      rst_n = 0; cfg_len = 5'd16; in_valid = 0; in_data = '0; flush = 0;
      req_ready = 0; out_ready = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      @(negedge clk);
      rst_n = 1;

      fill(16, 64'd0, 5'd16, 5'd16, 0);
      drain(0);
      fill(2, 64'hA0A0_0000_0000_000A, 5'd4, 5'd4, 0);
      cycle(0, 0, '0, 1, 5'd4, 0, 0);
      drain(0);
      fill(16, 64'h3300_0000_0000_0000, 5'd16, 5'd16, 0);
      drain(1);
      cycle(0, 0, '0, 1, 5'd16, 0, 0);
      cycle(0, 0, '0, 0, 5'd16, 0, 0);
      fill(3, 64'h4400_0000_0000_0000, 5'd16, 5'd16, 1);
      drain(1);
      fill(16, 64'h5500_0000_0000_0000, 5'd0, 5'd3, 0);
      drain(0);
      fill(16, 64'h5520_0000_0000_0000, 5'd20, 5'd5, 0);
      drain(1);

      repeat (3000) cycle(1, 0, '0, 0, '0, 0, 0);
      drain(0);

      fill(16, 64'h6600_0000_0000_0000, 5'd16, 5'd16, 0);
      for (int i = 0; i < 60 && !(phase == 2 && beat_idx >= 5); i++)
         cycle(0, 0, '0, 0, 5'd16, 1, 1);
      chk("pre_reset_beats", beat_idx, 5);
      @(negedge clk);
      rst_n = 0; in_valid = 0; flush = 0; req_ready = 0; out_ready = 0;
      @(posedge clk);
      #1;
      check_reset();
      model_reset();
      @(negedge clk);
      rst_n = 1;
      fill(3, 64'h7700_0000_0000_0000, 5'd16, 5'd16, 1);
      drain(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
